// File: rtl/scan_addr_gen_if.sv
// Control and RAM-port bundle for the pixel-scan address generator.
// The master side drives start/mode/hold/abort; the slave is the generator.
interface scan_addr_gen_if #(
  parameter int XW     = 6,
  parameter int YW     = 6,
  parameter int ADDR_W = 18
);
  logic              start;
  logic [2:0]        mode;
  logic              hold;
  logic              abort;
  logic              busy;
  logic              done;
  logic [XW+YW:0]    pix_cnt;
  logic              in_oe;
  logic [ADDR_W-1:0] in_a;
  logic              pic_we;
  logic [ADDR_W-1:0] pic_a;
  logic              w_we;
  logic [ADDR_W-1:0] w_a;

  modport master (
    output start, mode, hold, abort,
    input  busy, done, pix_cnt, in_oe, in_a, pic_we, pic_a, w_we, w_a
  );

  modport slave (
    input  start, mode, hold, abort,
    output busy, done, pix_cnt, in_oe, in_a, pic_we, pic_a, w_we, w_a
  );
endinterface

// File: rtl/scan_addr_gen.sv
// Pixel-scan address generator: walks a 2^XW x 2^YW image in one of eight
// orders, issuing input-RAM reads and, one cycle later, the matching
// picture-RAM writes (plus weight-RAM writes for the low WB_DEPTH addresses).
module scan_addr_gen #(
  parameter int XW       = 6,
  parameter int YW       = 6,
  parameter int ADDR_W   = 18,
  parameter int WB_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  scan_addr_gen_if.slave  bus
);

  // Count value of the final pixel; its issue ends the scan.
  localparam logic [XW+YW:0] LAST_PIX = {1'b0, {(XW+YW){1'b1}}};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state_reg;
  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic [XW+YW:0]    pix_cnt_reg;
  logic [2:0]        mode_reg;
  logic              valid_d_reg;
  logic [ADDR_W-1:0] addr_d_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              issue;
  logic [ADDR_W-1:0] in_a_next;
  logic              x_at_end;
  logic              y_at_end;
  logic [XW-1:0]     x_first;
  logic [YW-1:0]     y_first;
  logic [XW-1:0]     x_step;
  logic [YW-1:0]     y_step;
  logic              in_window;

  // Issue one read per unheld SCAN cycle; address is the current pixel.
  assign issue     = (state_reg == SCAN) && !bus.hold;
  assign in_a_next = ADDR_W'({y_reg, x_reg});

  // Per-axis direction decode from the latched mode.
  assign x_first  = mode_reg[1] ? '0 : '1;
  assign y_first  = mode_reg[0] ? '0 : '1;
  assign x_at_end = mode_reg[1] ? (x_reg == '1) : (x_reg == '0);
  assign y_at_end = mode_reg[0] ? (y_reg == '1) : (y_reg == '0);
  assign x_step   = mode_reg[1] ? x_reg + 1'b1 : x_reg - 1'b1;
  assign y_step   = mode_reg[0] ? y_reg + 1'b1 : y_reg - 1'b1;

  // Weight RAM only covers the first WB_DEPTH picture addresses.
  assign in_window = addr_d_reg < ADDR_W'(WB_DEPTH);

  // Scan FSM with pixel counters, busy/done flags and the one-cycle read-latency stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      pix_cnt_reg <= '0;
      mode_reg    <= '0;
      valid_d_reg <= 1'b0;
      addr_d_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      valid_d_reg <= issue && !bus.abort;
      addr_d_reg  <= in_a_next;
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_reg   <= SCAN;
            busy_reg    <= 1'b1;
            mode_reg    <= bus.mode;
            x_reg       <= bus.mode[1] ? '0 : '1;
            y_reg       <= bus.mode[0] ? '0 : '1;
            pix_cnt_reg <= '0;
          end
        end
        SCAN: begin
          if (bus.abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (issue) begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
            if (pix_cnt_reg == LAST_PIX) begin
              // Final pixel issued: leave counters on it and flush the last write.
              state_reg <= DRAIN;
              done_reg  <= 1'b1;
            end else if (!mode_reg[2]) begin
              // Row-major: x is the fast axis.
              if (x_at_end) begin
                x_reg <= x_first;
                y_reg <= y_step;
              end else begin
                x_reg <= x_step;
              end
            end else begin
              // Column-major: y is the fast axis.
              if (y_at_end) begin
                y_reg <= y_first;
                x_reg <= x_step;
              end else begin
                y_reg <= y_step;
              end
            end
          end
        end
        DRAIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.pix_cnt = pix_cnt_reg;
  assign bus.in_oe   = issue;
  assign bus.in_a    = in_a_next;
  assign bus.pic_we  = valid_d_reg;
  assign bus.pic_a   = addr_d_reg;
  assign bus.w_we    = valid_d_reg && in_window;
  assign bus.w_a     = in_window ? addr_d_reg : '0;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Self-checking bench for scan_addr_gen (XW=YW=6, WB_DEPTH=64).
module tb_scan_addr_gen;

  localparam int XW = 6;
  localparam int YW = 6;
  localparam int AW = 18;
  localparam int W  = 1 << XW;
  localparam int NP = 1 << (XW + YW);

  logic clk;
  logic rst;

  scan_addr_gen_if #(.XW(XW), .YW(YW), .ADDR_W(AW)) bus ();

  scan_addr_gen #(.XW(XW), .YW(YW), .ADDR_W(AW), .WB_DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int q[$];

  typedef struct {
    logic [2:0] mode;
    int hold_start;
    int hold_len;
    int restart_cyc;
    int abort_cyc;
    int exp_done;
    int exp_first;
    int exp_last;
    int exp_w;
    int exp_pix;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference address for the k-th pixel of a scan in mode m.
  function automatic int exp_addr(input logic [2:0] m, input int k);
    int f, s, xi, yi, x, y;
    f = k % W;
    s = k / W;
    if (!m[2]) begin xi = f; yi = s; end
    else       begin yi = f; xi = s; end
    x = m[1] ? xi : (W - 1 - xi);
    y = m[0] ? yi : (W - 1 - yi);
    return y * W + x;
  endfunction

  task automatic run_scan(input int r);
    vec_t v;
    int issued, done_cyc, first_a, last_a, w_cnt, tail, exp_pa;
    bit scanning, exp_valid, exp_done, exp_oe, hold_i, abort_i, finished;
    v = tbl[r];
    q.delete();
    issued = 0; done_cyc = -1; first_a = -1; last_a = -1; w_cnt = 0; tail = 0;
    scanning = 1'b1; exp_valid = 1'b0; exp_done = 1'b0; finished = 1'b0;

    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = v.mode; bus.hold = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0, 0);
    chk("idle_in_oe", bus.in_oe, 0, 0);

    for (int c = 1; c <= 5000; c++) begin
      @(posedge clk); #1;
      hold_i  = (c >= v.hold_start) && (c < v.hold_start + v.hold_len);
      abort_i = (c == v.abort_cyc);
      bus.start = (c == v.restart_cyc);
      bus.mode  = ~v.mode;
      bus.hold  = hold_i;
      bus.abort = abort_i;
      @(negedge clk);

      exp_oe = scanning && !hold_i;
      chk("in_oe", bus.in_oe, exp_oe, c);
      if (exp_oe) begin
        chk("in_a", bus.in_a, exp_addr(v.mode, issued), c);
        if (first_a < 0) first_a = int'(bus.in_a);
      end
      chk("pic_we", bus.pic_we, exp_valid, c);
      if (exp_valid) begin
        exp_pa = q.pop_front();
        chk("pic_a", bus.pic_a, exp_pa, c);
        chk("w_we", bus.w_we, (exp_pa < 64), c);
        chk("w_a", bus.w_a, (exp_pa < 64) ? exp_pa : 0, c);
      end else begin
        chk("w_we_idle", bus.w_we, 0, c);
      end
      if (bus.w_we === 1'b1) w_cnt++;
      chk("done", bus.done, exp_done, c);
      chk("busy", bus.busy, scanning || exp_done, c);
      if (bus.done === 1'b1) done_cyc = c;

      // Advance the reference model to the next cycle.
      exp_done  = 1'b0;
      exp_valid = exp_oe && !abort_i;
      if (exp_oe && !abort_i) begin
        q.push_back(exp_addr(v.mode, issued));
        last_a = int'(bus.in_a);
        issued++;
        if (issued == NP) begin
          scanning = 1'b0;
          exp_done = 1'b1;
        end
      end
      if (abort_i) scanning = 1'b0;
      if (!scanning && !exp_valid && !exp_done) tail++;
      if (tail == 2) begin
        finished = 1'b1;
        break;
      end
    end

    bus.start = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
    if (!finished) chk("timeout", 1, 0, -1);
    chk("done_cycle", done_cyc, v.exp_done, r);
    chk("first_in_a", first_a, v.exp_first, r);
    chk("last_in_a", last_a, v.exp_last, r);
    chk("w_we_count", w_cnt, v.exp_w, r);
    chk("pix_cnt_end", bus.pix_cnt, v.exp_pix, r);
    chk("issued_count", issued, v.exp_pix, r);
    $display("scan %0d mode=%0d done_cycle=%0d issued=%0d pix_cnt=%0d errors=%0d",
             r, v.mode, done_cyc, issued, bus.pix_cnt, errors);
  endtask

  task automatic chk_all_zero(input string nm, input int cyc);
    chk({nm, "_busy"}, bus.busy, 0, cyc);
    chk({nm, "_done"}, bus.done, 0, cyc);
    chk({nm, "_pix_cnt"}, bus.pix_cnt, 0, cyc);
    chk({nm, "_in_oe"}, bus.in_oe, 0, cyc);
    chk({nm, "_in_a"}, bus.in_a, 0, cyc);
    chk({nm, "_pic_we"}, bus.pic_we, 0, cyc);
    chk({nm, "_pic_a"}, bus.pic_a, 0, cyc);
    chk({nm, "_w_we"}, bus.w_we, 0, cyc);
    chk({nm, "_w_a"}, bus.w_a, 0, cyc);
  endtask

  initial begin
    //            mode  hs  hl  rs   ab   done  first last  w   pix
    tbl[0] = '{3'd3,  0,  0,  0,   0, 4097,    0, 4095, 64, 4096};
    tbl[1] = '{3'd0,  0,  0,  0,   0, 4097, 4095,    0, 64, 4096};
    tbl[2] = '{3'd1,  0,  0,  0,   0, 4097,   63, 4032, 64, 4096};
    tbl[3] = '{3'd2,  0,  0,  0,   0, 4097, 4032,   63, 64, 4096};
    tbl[4] = '{3'd7,  0,  0,  0,   0, 4097,    0, 4095, 64, 4096};
    tbl[5] = '{3'd3, 10,  3, 11,   0, 4100,    0, 4095, 64, 4096};
    tbl[6] = '{3'd3,  0,  0, 50, 100,   -1,    0,   98, 64,   99};

    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 3'd0; bus.hold = 1'b0; bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) run_scan(r);

    // Asynchronous reset in the middle of a scan.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 3'd3;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("pre_rst_busy", bus.busy, 1, 50);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst", 50);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", bus.done, 0, 51);
      chk("post_rst_busy", bus.busy, 0, 51);
    end
    $display("async reset test complete errors=%0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
